reg_write_arbiter: RTL and testbench
====================================

# reg_write_arbiter

- Shares the register-file single write port (`RegWrite`/`WriteReg`/`WriteData`) between two writeback requesters:
  - ALU/R-type results.
  - Memory load results.
- Each requester uses a valid/ready handshake. Arbitration is round-robin.
- The winning write is registered and driven to the register file one cycle later.
- A saturating conflict counter supports stall profiling.
- Sits between the pipeline writeback stage and the register file.

## Interface
Parameters:
- `CNT_W`, default 8: width of the conflict counter.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `freeze`  in  1  while high, no requester is granted and no write is issued.
- `alu_valid`  in  1  ALU write request pending.
- `alu_reg`  in  5  ALU destination register.
- `alu_data`  in  32  ALU write data.
- `alu_ready`  out  1  ALU request accepted this cycle (combinational).
- `mem_valid`  in  1  load write request pending.
- `mem_reg`  in  5  load destination register.
- `mem_data`  in  32  load write data.
- `mem_ready`  out  1  load request accepted this cycle (combinational).
- `RegWrite`  out  1  registered write enable to the register file.
- `WriteReg`  out  5  registered write address.
- `WriteData`  out  32  registered write data.
- `cnt_clr`  in  1  synchronous clear of `conflict_cnt`.
- `conflict_cnt`  out  CNT_W  saturating count of contested cycles.

## Operation
- Transfer rule: a transfer occurs on `valid && ready`. A requester holds `valid`, `reg` and `data` stable until it sees `ready`.
- Grant logic, evaluated each cycle while `freeze=0`:
  - Only one requester valid: it is granted.
  - Both valid: the one not granted most recently is granted; the other sees `ready=0`.
  - Neither valid: no grant, and the pointer is unchanged.
- Round-robin pointer `last_grant` (1 bit: 0=ALU, 1=MEM):
  - Updates only on an actual grant.
  - Reset value is MEM, so ALU wins the first contest.
- Write issue: a granted request loads the output register (`RegWrite=1`, `WriteReg`, `WriteData`) at the next edge. A cycle with no grant loads `RegWrite=0`.
- `WriteReg` and `WriteData` hold their last values when `RegWrite=0`.
- Same-register conflict: both requests are written in grant order on consecutive cycles. The later one wins in the register file, and no merging is done.
- `freeze=1`:
  - Both `ready` outputs are 0.
  - `RegWrite` goes 0 at the next edge.
  - The pointer and counter do not change.
- Conflict counter:
  - Increments on each cycle with `alu_valid && mem_valid && !freeze` after zero-filtering (see Configuration).
  - Saturates at all-ones.
  - `cnt_clr` has priority over increment.

## Timing
- Latency from the accept edge to the register-file write: 1 cycle (the write lands at the edge following `RegWrite=1`).
- Throughput: one write per cycle sustained. Under continuous contention, ALU and MEM alternate.
- `ready` depends only on `valid`, `freeze`, `last_grant` and the zero-filter. It never depends on `RegWrite`.
- Reset values: `RegWrite=0`, `WriteReg=0`, `WriteData=0`, `conflict_cnt=0`, `last_grant=MEM`.
- Reset asserted mid-operation:
  - An output write not yet committed is dropped.
  - Requesters must re-present their requests after reset deasserts.
  - `ready` is 0 while reset is high.

## Configuration
- `REG_ARB_ZERO_FILTER_EN`, defined:
  - A request to register 0 is accepted immediately (`ready=1`) independent of arbitration and `last_grant`, and generates no write.
  - Such a request does not count as contest for the counter or the pointer.
  - If both requests target register 0, both are accepted the same cycle.
- `REG_ARB_ZERO_FILTER_EN`, undefined: register 0 requests arbitrate and issue like any other write.

## Structure
- A shared package holds:
  - `REG_ADDR_W=5` and `REG_DATA_W=32`.
  - The requester ID constants `REQ_ALU=1'b0` and `REQ_MEM=1'b1`.
- One natural sub-module: `rr_arb2`, a 2-way round-robin grant with a pointer register.
- The top holds the zero-filter, the output register and the counter.

## Test plan
- Reset, then ALU only, `alu_reg=8`, `alu_data=32'h1234`:
  - `alu_ready=1` in the same cycle.
  - Next cycle: `RegWrite=1`, `WriteReg=8`, `WriteData=32'h1234`.
- Both valid for 4 cycles (ALU→r9=20, MEM→r10=22):
  - Grants in order ALU, MEM, ALU, MEM.
  - `conflict_cnt=4`.
  - Each stalled requester sees `ready=0`.
- Both target r11 (ALU=40, MEM=80) after reset: two consecutive writes, 40 then 80. The final r11 value is 80.
- `freeze=1` with both valid for 3 cycles:
  - Both `ready=0` and `RegWrite=0`.
  - Counter is unchanged.
  - Releasing `freeze` grants per the retained pointer.
- With `REG_ARB_ZERO_FILTER_EN`, ALU→r0 and MEM→r12=50 together:
  - Both ready in the same cycle.
  - Next cycle: `RegWrite=1`, `WriteReg=12`.
  - Counter is unchanged.
- Assert `reset` the cycle after a grant: `RegWrite` is 0 immediately, and no write is issued after deassert. Counter saturation is checked with `CNT_W=2`: the count stays at 3.

Source files
------------

// File: rtl/reg_write_arbiter_pkg.sv
// Shared widths and requester IDs for the register-file write arbiter.
// Imported by the arbiter top and its round-robin grant sub-module.
package reg_write_arbiter_pkg;
    localparam int   REG_ADDR_W = 5;
    localparam int   REG_DATA_W = 32;
    localparam logic REQ_ALU    = 1'b0;
    localparam logic REQ_MEM    = 1'b1;
endpackage

// File: rtl/reg_write_arbiter_rr_arb2.sv
// 2-way round-robin grant: combinational grant, registered last-grant pointer.
// Grant is same-cycle; requests are held off by en=0 and the pointer then holds.
module rr_arb2
    import reg_write_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output logic       last_grant
);

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                // Contest: whoever did not win most recently goes first.
                2'b11:   gnt = (last_grant == REQ_MEM) ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= REQ_MEM;
        end else if (gnt[REQ_MEM]) begin
            last_grant <= REQ_MEM;
        end else if (gnt[REQ_ALU]) begin
            last_grant <= REQ_ALU;
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Shares the register-file write port between ALU and load writeback, round-robin.
// Optional REG_ARB_ZERO_FILTER_EN: r0 requests are accepted at once and never written.
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  freeze,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_reg,
    input  logic [REG_DATA_W-1:0] alu_data,
    output logic                  alu_ready,
    input  logic                  mem_valid,
    input  logic [REG_ADDR_W-1:0] mem_reg,
    input  logic [REG_DATA_W-1:0] mem_data,
    output logic                  mem_ready,
    output logic                  RegWrite,
    output logic [REG_ADDR_W-1:0] WriteReg,
    output logic [REG_DATA_W-1:0] WriteData,
    input  logic                  cnt_clr,
    output logic [CNT_W-1:0]      conflict_cnt
);

    logic       alu_zero;
    logic       mem_zero;
    logic [1:0] arb_req;
    logic [1:0] gnt;
    logic       last_grant;
    logic       arb_en;
    logic       contest;

`ifdef REG_ARB_ZERO_FILTER_EN
    assign alu_zero = alu_valid && (alu_reg == '0);
    assign mem_zero = mem_valid && (mem_reg == '0);
`else
    assign alu_zero = 1'b0;
    assign mem_zero = 1'b0;
`endif

    // Writes to r0 are swallowed before arbitration, so they never contest.
    always_comb begin
        arb_req          = 2'b00;
        arb_req[REQ_ALU] = alu_valid && !alu_zero;
        arb_req[REQ_MEM] = mem_valid && !mem_zero;
    end

    assign arb_en  = !freeze && !reset;
    assign contest = arb_req[REQ_ALU] && arb_req[REQ_MEM] && !freeze;

    rr_arb2 u_rr_arb2 (
        .clk        (clk),
        .reset      (reset),
        .en         (arb_en),
        .req        (arb_req),
        .gnt        (gnt),
        .last_grant (last_grant)
    );

    assign alu_ready = arb_en && (gnt[REQ_ALU] || alu_zero);
    assign mem_ready = arb_en && (gnt[REQ_MEM] || mem_zero);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            RegWrite  <= 1'b0;
            WriteReg  <= '0;
            WriteData <= '0;
        end else begin
            RegWrite <= |gnt;
            if (gnt[REQ_ALU]) begin
                WriteReg  <= alu_reg;
                WriteData <= alu_data;
            end else if (gnt[REQ_MEM]) begin
                WriteReg  <= mem_reg;
                WriteData <= mem_data;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            conflict_cnt <= '0;
        end else if (cnt_clr) begin
            conflict_cnt <= '0;
        end else if (contest && (conflict_cnt != '1)) begin
            conflict_cnt <= conflict_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter; a second CNT_W=2 instance on the same inputs covers saturation.
// Tracks a shadow register file to confirm which value finally lands.
module tb_reg_write_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        freeze;
    logic        alu_valid;
    logic [4:0]  alu_reg;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        mem_valid;
    logic [4:0]  mem_reg;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic        RegWrite;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic        cnt_clr;
    logic [7:0]  conflict_cnt;

    logic        alu_ready2;
    logic        mem_ready2;
    logic        RegWrite2;
    logic [4:0]  WriteReg2;
    logic [31:0] WriteData2;
    logic [1:0]  conflict_cnt2;

    logic [31:0] rf [32];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    reg_write_arbiter #(.CNT_W(8)) dut (
        .clk(clk), .reset(reset), .freeze(freeze),
        .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data), .mem_ready(mem_ready),
        .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
        .cnt_clr(cnt_clr), .conflict_cnt(conflict_cnt)
    );

    reg_write_arbiter #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .freeze(freeze),
        .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_ready(alu_ready2),
        .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data), .mem_ready(mem_ready2),
        .RegWrite(RegWrite2), .WriteReg(WriteReg2), .WriteData(WriteData2),
        .cnt_clr(cnt_clr), .conflict_cnt(conflict_cnt2)
    );

    always @(posedge clk) begin
        if (RegWrite) rf[WriteReg] <= WriteData;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        freeze    = 1'b0;
        alu_valid = 1'b0;
        alu_reg   = 5'd0;
        alu_data  = 32'd0;
        mem_valid = 1'b0;
        mem_reg   = 5'd0;
        mem_data  = 32'd0;
        cnt_clr   = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset     = 1'b1;
        alu_valid = 1'b1;
        alu_reg   = 5'd3;
        tick();
        n_checks++;
        if (alu_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", alu_ready); end
        n_checks++;
        if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL reset_regwrite: got %b want 0", RegWrite); end
        n_checks++;
        if (WriteReg !== 5'd0 || WriteData !== 32'd0) begin
            n_fail++; $display("FAIL reset_wr: got %0d/%h want 0/0", WriteReg, WriteData);
        end
        n_checks++;
        if (conflict_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", conflict_cnt); end
        alu_valid = 1'b0;
        reset     = 1'b0;
    endtask

    task automatic test_alu_only();
        do_reset();
        alu_valid = 1'b1; alu_reg = 5'd8; alu_data = 32'h1234;
        #1;
        n_checks++;
        if (alu_ready !== 1'b1 || mem_ready !== 1'b0) begin
            n_fail++; $display("FAIL alu_only_ready: got %b%b want 10", alu_ready, mem_ready);
        end
        tick();
        alu_valid = 1'b0;
        n_checks++;
        if (RegWrite !== 1'b1 || WriteReg !== 5'd8 || WriteData !== 32'h1234) begin
            n_fail++; $display("FAIL alu_only_write: got %b/%0d/%h want 1/8/1234", RegWrite, WriteReg, WriteData);
        end
        tick();
        n_checks++;
        if (RegWrite !== 1'b0 || WriteReg !== 5'd8 || WriteData !== 32'h1234) begin
            n_fail++; $display("FAIL idle_hold: got %b/%0d/%h want 0/8/1234", RegWrite, WriteReg, WriteData);
        end
    endtask

    task automatic test_contention();
        do_reset();
        alu_valid = 1'b1; alu_reg = 5'd9;  alu_data = 32'd20;
        mem_valid = 1'b1; mem_reg = 5'd10; mem_data = 32'd22;
        for (int i = 0; i < 4; i++) begin
            logic alu_win;
            alu_win = (i % 2 == 0);
            #1;
            n_checks++;
            if (alu_ready !== alu_win || mem_ready !== !alu_win) begin
                n_fail++; $display("FAIL contend_ready[%0d]: got %b%b want %b%b", i, alu_ready, mem_ready, alu_win, !alu_win);
            end
            tick();
            n_checks++;
            if (RegWrite !== 1'b1 || WriteReg !== (alu_win ? 5'd9 : 5'd10) || WriteData !== (alu_win ? 32'd20 : 32'd22)) begin
                n_fail++; $display("FAIL contend_write[%0d]: got %b/%0d/%0d", i, RegWrite, WriteReg, WriteData);
            end
            n_checks++;
            if (RegWrite2 !== 1'b1 || WriteReg2 !== (alu_win ? 5'd9 : 5'd10) || WriteData2 !== (alu_win ? 32'd20 : 32'd22)
                || alu_ready2 !== alu_ready || mem_ready2 !== mem_ready) begin
                n_fail++; $display("FAIL contend_dut2[%0d]: got %b/%0d/%0d", i, RegWrite2, WriteReg2, WriteData2);
            end
        end
        n_checks++;
        if (conflict_cnt !== 8'd4) begin n_fail++; $display("FAIL contend_cnt: got %0d want 4", conflict_cnt); end
        n_checks++;
        if (conflict_cnt2 !== 2'd3) begin n_fail++; $display("FAIL cnt_saturate: got %0d want 3", conflict_cnt2); end
        tick();
        n_checks++;
        if (conflict_cnt2 !== 2'd3) begin n_fail++; $display("FAIL cnt_saturate_hold: got %0d want 3", conflict_cnt2); end
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        n_checks++;
        if (conflict_cnt !== 8'd0 || conflict_cnt2 !== 2'd0) begin
            n_fail++; $display("FAIL cnt_clr_priority: got %0d/%0d want 0/0", conflict_cnt, conflict_cnt2);
        end
        tick();
        n_checks++;
        if (conflict_cnt !== 8'd1) begin n_fail++; $display("FAIL cnt_after_clr: got %0d want 1", conflict_cnt); end
        idle_inputs();
    endtask

    task automatic test_same_reg();
        do_reset();
        alu_valid = 1'b1; alu_reg = 5'd11; alu_data = 32'd40;
        mem_valid = 1'b1; mem_reg = 5'd11; mem_data = 32'd80;
        #1;
        n_checks++;
        if (alu_ready !== 1'b1 || mem_ready !== 1'b0) begin
            n_fail++; $display("FAIL same_reg_first: got %b%b want 10", alu_ready, mem_ready);
        end
        tick();
        alu_valid = 1'b0;
        n_checks++;
        if (RegWrite !== 1'b1 || WriteReg !== 5'd11 || WriteData !== 32'd40) begin
            n_fail++; $display("FAIL same_reg_w1: got %b/%0d/%0d want 1/11/40", RegWrite, WriteReg, WriteData);
        end
        tick();
        mem_valid = 1'b0;
        n_checks++;
        if (RegWrite !== 1'b1 || WriteReg !== 5'd11 || WriteData !== 32'd80) begin
            n_fail++; $display("FAIL same_reg_w2: got %b/%0d/%0d want 1/11/80", RegWrite, WriteReg, WriteData);
        end
        tick();
        n_checks++;
        if (rf[11] !== 32'd80 || RegWrite !== 1'b0) begin
            n_fail++; $display("FAIL same_reg_final: got r11=%0d we=%b want 80/0", rf[11], RegWrite);
        end
    endtask

    task automatic test_freeze();
        do_reset();
        alu_valid = 1'b1; alu_reg = 5'd1; alu_data = 32'd1;
        mem_valid = 1'b1; mem_reg = 5'd2; mem_data = 32'd2;
        tick();
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (alu_ready !== 1'b0 || mem_ready !== 1'b0) begin
                n_fail++; $display("FAIL freeze_ready[%0d]: got %b%b want 00", i, alu_ready, mem_ready);
            end
            tick();
            n_checks++;
            if (RegWrite !== 1'b0 || conflict_cnt !== 8'd1) begin
                n_fail++; $display("FAIL freeze_hold[%0d]: got we=%b cnt=%0d want 0/1", i, RegWrite, conflict_cnt);
            end
        end
        freeze = 1'b0;
        #1;
        n_checks++;
        if (alu_ready !== 1'b0 || mem_ready !== 1'b1) begin
            n_fail++; $display("FAIL unfreeze_ready: got %b%b want 01", alu_ready, mem_ready);
        end
        tick();
        n_checks++;
        if (RegWrite !== 1'b1 || WriteReg !== 5'd2 || conflict_cnt !== 8'd2) begin
            n_fail++; $display("FAIL unfreeze_write: got %b/%0d cnt=%0d want 1/2/2", RegWrite, WriteReg, conflict_cnt);
        end
        idle_inputs();
    endtask

    task automatic test_zero_filter();
        do_reset();
        alu_valid = 1'b1; alu_reg = 5'd0;  alu_data = 32'd5;
        mem_valid = 1'b1; mem_reg = 5'd12; mem_data = 32'd50;
        #1;
`ifdef REG_ARB_ZERO_FILTER_EN
        n_checks++;
        if (alu_ready !== 1'b1 || mem_ready !== 1'b1) begin
            n_fail++; $display("FAIL zero_ready: got %b%b want 11", alu_ready, mem_ready);
        end
        tick();
        n_checks++;
        if (RegWrite !== 1'b1 || WriteReg !== 5'd12 || WriteData !== 32'd50 || conflict_cnt !== 8'd0) begin
            n_fail++; $display("FAIL zero_write: got %b/%0d/%0d cnt=%0d want 1/12/50/0", RegWrite, WriteReg, WriteData, conflict_cnt);
        end
`else
        n_checks++;
        if (alu_ready !== 1'b1 || mem_ready !== 1'b0) begin
            n_fail++; $display("FAIL zero_ready: got %b%b want 10", alu_ready, mem_ready);
        end
        tick();
        n_checks++;
        if (RegWrite !== 1'b1 || WriteReg !== 5'd0 || WriteData !== 32'd5 || conflict_cnt !== 8'd1) begin
            n_fail++; $display("FAIL zero_write: got %b/%0d/%0d cnt=%0d want 1/0/5/1", RegWrite, WriteReg, WriteData, conflict_cnt);
        end
`endif
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        alu_valid = 1'b1; alu_reg = 5'd13; alu_data = 32'd77;
        tick();
        n_checks++;
        if (RegWrite !== 1'b1 || WriteReg !== 5'd13) begin
            n_fail++; $display("FAIL mid_grant: got %b/%0d want 1/13", RegWrite, WriteReg);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (RegWrite !== 1'b0 || alu_ready !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset: got we=%b rdy=%b want 0/0", RegWrite, alu_ready);
        end
        alu_valid = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        n_checks++;
        if (RegWrite !== 1'b0 || WriteReg !== 5'd0 || rf[13] !== 32'd0) begin
            n_fail++; $display("FAIL mid_after: got we=%b reg=%0d r13=%0d want 0/0/0", RegWrite, WriteReg, rf[13]);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        idle_inputs();
        reset = 1'b1;
        #2;
        test_reset();
        test_alu_only();
        test_contention();
        test_same_reg();
        test_freeze();
        test_zero_filter();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
